// File: rtl/id_ex_hazard_stage_if.sv
// Bundle between the ID stage, the ID/EX register and its hazard control.
// The slave modport is the pipeline-register side; master is the decode/driver side.
interface id_ex_hazard_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic [4:0]        IFID_RegRs__i;
    logic [4:0]        IFID_RegRt__i;
    logic [4:0]        IFID_RegRd__i;
    logic [DATA_W-1:0] IFID_RsData__i;
    logic [DATA_W-1:0] IFID_RtData__i;
    logic [DATA_W-1:0] IFID_Imm__i;
    logic              RegWrite__i;
    logic              MemRead__i;
    logic              MemWrite__i;
    logic              MemToReg__i;
    logic              RegDst__i;
    logic              ALUSrc__i;
    logic              Branch__i;
    logic [3:0]        ALUOp__i;
    logic              Flush__i;

    logic [4:0]        IDEX_RegRs__o;
    logic [4:0]        IDEX_RegRt__o;
    logic [4:0]        IDEX_RegRd__o;
    logic [DATA_W-1:0] IDEX_RsData__o;
    logic [DATA_W-1:0] IDEX_RtData__o;
    logic [DATA_W-1:0] IDEX_Imm__o;
    logic              IDEX_RegWrite__o;
    logic              IDEX_MemRead__o;
    logic              IDEX_MemWrite__o;
    logic              IDEX_MemToReg__o;
    logic              IDEX_ALUSrc__o;
    logic [3:0]        IDEX_ALUOp__o;
    logic              PCWrite__o;
    logic              IFIDWrite__o;
    logic              Stall__o;
    logic [15:0]       StallCount__o;

    modport master (
        output IFID_RegRs__i, IFID_RegRt__i, IFID_RegRd__i,
        output IFID_RsData__i, IFID_RtData__i, IFID_Imm__i,
        output RegWrite__i, MemRead__i, MemWrite__i, MemToReg__i,
        output RegDst__i, ALUSrc__i, Branch__i, ALUOp__i, Flush__i,
        input  IDEX_RegRs__o, IDEX_RegRt__o, IDEX_RegRd__o,
        input  IDEX_RsData__o, IDEX_RtData__o, IDEX_Imm__o,
        input  IDEX_RegWrite__o, IDEX_MemRead__o, IDEX_MemWrite__o,
        input  IDEX_MemToReg__o, IDEX_ALUSrc__o, IDEX_ALUOp__o,
        input  PCWrite__o, IFIDWrite__o, Stall__o, StallCount__o
    );

    modport slave (
        input  IFID_RegRs__i, IFID_RegRt__i, IFID_RegRd__i,
        input  IFID_RsData__i, IFID_RtData__i, IFID_Imm__i,
        input  RegWrite__i, MemRead__i, MemWrite__i, MemToReg__i,
        input  RegDst__i, ALUSrc__i, Branch__i, ALUOp__i, Flush__i,
        output IDEX_RegRs__o, IDEX_RegRt__o, IDEX_RegRd__o,
        output IDEX_RsData__o, IDEX_RtData__o, IDEX_Imm__o,
        output IDEX_RegWrite__o, IDEX_MemRead__o, IDEX_MemWrite__o,
        output IDEX_MemToReg__o, IDEX_ALUSrc__o, IDEX_ALUOp__o,
        output PCWrite__o, IFIDWrite__o, Stall__o, StallCount__o
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / branch hazard detection and bubble injection.
// Optional stall-cycle statistics counter enabled by defining HAZARD_STATS_EN.
module id_ex_hazard_stage #(
    parameter int unsigned DATA_W = 32
) (
    input logic                 clk__i,
    input logic                 reset_n__i,
    id_ex_hazard_stage_if.slave bus
);

    typedef enum logic {
        S_RUN,
        S_HOLD
    } state_t;

    state_t state_q, state_d;

    logic [4:0]        rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic              reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, alu_src_q;
    logic [3:0]        alu_op_q;

    logic rt_used;
    logic match_rs, match_rt, match_any;
    logic load_use, branch_alu, branch_load, hazard;
    logic stall;
    logic bubble;

    // Rt is a true source for R-type ops, stores (store data) and branches (compare).
    assign rt_used  = ~bus.ALUSrc__i | bus.MemWrite__i | bus.Branch__i;
    assign match_rs = (bus.IFID_RegRs__i != 5'd0) && (bus.IFID_RegRs__i == rd_q);
    assign match_rt = rt_used && (bus.IFID_RegRt__i != 5'd0) && (bus.IFID_RegRt__i == rd_q);
    assign match_any = match_rs | match_rt;

    assign load_use    = mem_read_q & match_any;
    assign branch_alu  = bus.Branch__i & reg_write_q & ~mem_read_q & match_any;
    assign branch_load = bus.Branch__i & mem_read_q & match_any;
    assign hazard      = load_use | branch_alu | branch_load;

    always_ff @(posedge clk__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            S_RUN: begin
                stall = hazard;
                if (branch_load) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                stall   = 1'b1;
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
        // A flush squashes the instruction that caused the hazard, so no stall may remain pending.
        if (bus.Flush__i) begin
            state_d = S_RUN;
        end
    end

    assign bubble = stall | bus.Flush__i;

    always_ff @(posedge clk__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= '0;
        end else if (bubble) begin
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= '0;
        end else begin
            rs_q         <= bus.IFID_RegRs__i;
            rt_q         <= bus.IFID_RegRt__i;
            rd_q         <= bus.RegDst__i ? bus.IFID_RegRd__i : bus.IFID_RegRt__i;
            rs_data_q    <= bus.IFID_RsData__i;
            rt_data_q    <= bus.IFID_RtData__i;
            imm_q        <= bus.IFID_Imm__i;
            reg_write_q  <= bus.RegWrite__i;
            mem_read_q   <= bus.MemRead__i;
            mem_write_q  <= bus.MemWrite__i;
            mem_to_reg_q <= bus.MemToReg__i;
            alu_src_q    <= bus.ALUSrc__i;
            alu_op_q     <= bus.ALUOp__i;
        end
    end

    assign bus.IDEX_RegRs__o    = rs_q;
    assign bus.IDEX_RegRt__o    = rt_q;
    assign bus.IDEX_RegRd__o    = rd_q;
    assign bus.IDEX_RsData__o   = rs_data_q;
    assign bus.IDEX_RtData__o   = rt_data_q;
    assign bus.IDEX_Imm__o      = imm_q;
    assign bus.IDEX_RegWrite__o = reg_write_q;
    assign bus.IDEX_MemRead__o  = mem_read_q;
    assign bus.IDEX_MemWrite__o = mem_write_q;
    assign bus.IDEX_MemToReg__o = mem_to_reg_q;
    assign bus.IDEX_ALUSrc__o   = alu_src_q;
    assign bus.IDEX_ALUOp__o    = alu_op_q;

    assign bus.Stall__o     = stall;
    assign bus.PCWrite__o   = ~stall;
    assign bus.IFIDWrite__o = ~stall;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.StallCount__o = stall_cnt_q;
`else
    assign bus.StallCount__o = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: a stall-budget model checked every cycle
// plus hand-computed expectations along the MIPS hazard scenarios.
module tb_id_ex_hazard_stage;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    id_ex_hazard_stage_if #(.DATA_W(DW)) bus ();

    id_ex_hazard_stage #(.DATA_W(DW)) dut (
        .clk__i     (clk),
        .reset_n__i (reset_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what sits in ID/EX, plus how many forced stall cycles are still owed.
    typedef struct packed {
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] rsd, rtd, imm;
        logic          rw, mr, mw, m2r, asrc;
        logic [3:0]    aop;
    } idex_t;

    idex_t m = '0;
    int    owed = 0;
    int    stats = 0;

    function automatic int bubbles_needed();
        bit dep;
        bit rt_src;
        rt_src = !bus.ALUSrc__i || bus.MemWrite__i || bus.Branch__i;
        dep = (bus.IFID_RegRs__i != 0 && bus.IFID_RegRs__i == m.rd) ||
              (rt_src && bus.IFID_RegRt__i != 0 && bus.IFID_RegRt__i == m.rd);
        if (!dep) return 0;
        if (bus.Branch__i && m.mr) return 2;
        if (m.mr || (bus.Branch__i && m.rw)) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        return (owed > 0) || (bubbles_needed() > 0);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m = '0;
            owed = 0;
            stats = 0;
        end else begin
            int b;
            bit s;
            b = bubbles_needed();
            s = model_stall();
            if (s && stats < 65535) stats++;
            if (owed > 0) owed--;
            else if (b == 2) owed = 1;
            if (bus.Flush__i) owed = 0;
            if (s || bus.Flush__i) begin
                m = '0;
            end else begin
                m.rs   = bus.IFID_RegRs__i;
                m.rt   = bus.IFID_RegRt__i;
                m.rd   = bus.RegDst__i ? bus.IFID_RegRd__i : bus.IFID_RegRt__i;
                m.rsd  = bus.IFID_RsData__i;
                m.rtd  = bus.IFID_RtData__i;
                m.imm  = bus.IFID_Imm__i;
                m.rw   = bus.RegWrite__i;
                m.mr   = bus.MemRead__i;
                m.mw   = bus.MemWrite__i;
                m.m2r  = bus.MemToReg__i;
                m.asrc = bus.ALUSrc__i;
                m.aop  = bus.ALUOp__i;
            end
        end
    end

    always @(negedge clk) begin
        bit s;
        s = model_stall();
        check("Stall", 32'(bus.Stall__o), 32'(s));
        check("PCWrite", 32'(bus.PCWrite__o), 32'(!s));
        check("IFIDWrite", 32'(bus.IFIDWrite__o), 32'(!s));
        check("RegRs", 32'(bus.IDEX_RegRs__o), 32'(m.rs));
        check("RegRt", 32'(bus.IDEX_RegRt__o), 32'(m.rt));
        check("RegRd", 32'(bus.IDEX_RegRd__o), 32'(m.rd));
        check("RsData", bus.IDEX_RsData__o, m.rsd);
        check("RtData", bus.IDEX_RtData__o, m.rtd);
        check("Imm", bus.IDEX_Imm__o, m.imm);
        check("ctrl", {27'd0, bus.IDEX_RegWrite__o, bus.IDEX_MemRead__o, bus.IDEX_MemWrite__o,
                       bus.IDEX_MemToReg__o, bus.IDEX_ALUSrc__o},
                      {27'd0, m.rw, m.mr, m.mw, m.m2r, m.asrc});
        check("ALUOp", 32'(bus.IDEX_ALUOp__o), 32'(m.aop));
`ifdef HAZARD_STATS_EN
        check("StallCount", 32'(bus.StallCount__o), 32'(stats));
`else
        check("StallCount", 32'(bus.StallCount__o), 32'd0);
`endif
    end

    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input bit rdst, input bit asrc, input bit rw, input bit mr,
                         input bit mw, input bit m2r, input bit br, input logic [3:0] aop);
        bus.IFID_RegRs__i  = rs;
        bus.IFID_RegRt__i  = rt;
        bus.IFID_RegRd__i  = rd;
        bus.IFID_RsData__i = 32'hA000_0000 | 32'(rs);
        bus.IFID_RtData__i = 32'hB000_0000 | 32'(rt);
        bus.IFID_Imm__i    = 32'hFFFF_FF00 | 32'(rd);
        bus.RegDst__i      = rdst;
        bus.ALUSrc__i      = asrc;
        bus.RegWrite__i    = rw;
        bus.MemRead__i     = mr;
        bus.MemWrite__i    = mw;
        bus.MemToReg__i    = m2r;
        bus.Branch__i      = br;
        bus.ALUOp__i       = aop;
    endtask

    task automatic nop();             instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0); endtask
    task automatic lw(input logic [4:0] rt, input logic [4:0] base);
                                      instr(base, rt, 0, 0, 1, 1, 1, 0, 1, 0, 4'd2); endtask
    task automatic sw(input logic [4:0] rt, input logic [4:0] base);
                                      instr(base, rt, 0, 0, 1, 0, 0, 1, 0, 0, 4'd2); endtask
    task automatic add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
                                      instr(rs, rt, rd, 1, 0, 1, 0, 0, 0, 0, 4'd2); endtask
    task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
                                      instr(rs, rt, 0, 0, 0, 0, 0, 0, 0, 1, 4'd6); endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.Flush__i = 1'b0;
        nop();
        reset_n = 1'b0;
        tick(); tick();
        check("rst_PCWrite", 32'(bus.PCWrite__o), 32'd1);
        check("rst_Stall", 32'(bus.Stall__o), 32'd0);
        reset_n = 1'b1;
        tick();

        // Load-use: lw $8 then add $9,$8,$2
        lw(8, 1);
        tick();
        add(9, 8, 2);
        peek();
        check("lu_memread", 32'(bus.IDEX_MemRead__o), 32'd1);
        check("lu_rd", 32'(bus.IDEX_RegRd__o), 32'd8);
        check("lu_stall", 32'(bus.Stall__o), 32'd1);
        tick();
        peek();
        check("lu_bubble_rw", 32'(bus.IDEX_RegWrite__o), 32'd0);
        check("lu_after", 32'(bus.Stall__o), 32'd0);
        tick();
        check("lu_add_rs", 32'(bus.IDEX_RegRs__o), 32'd8);
        check("lu_add_rd", 32'(bus.IDEX_RegRd__o), 32'd9);

        // Branch-load: lw $9 then beq $3,$9 -> two stalls
        lw(9, 1);
        tick();
        beq(3, 9);
        peek();
        check("bl_stall1", 32'(bus.Stall__o), 32'd1);
        check("bl_ifid1", 32'(bus.IFIDWrite__o), 32'd0);
        tick();
        peek();
        check("bl_stall2", 32'(bus.Stall__o), 32'd1);
        check("bl_ifid2", 32'(bus.IFIDWrite__o), 32'd0);
        tick();
        peek();
        check("bl_release", 32'(bus.Stall__o), 32'd0);
`ifdef HAZARD_STATS_EN
        check("stats3", 32'(bus.StallCount__o), 32'd3);
`else
        check("stats0", 32'(bus.StallCount__o), 32'd0);
`endif
        tick();
        check("bl_beq_rt", 32'(bus.IDEX_RegRt__o), 32'd9);

        // Branch-ALU: add $10 then beq $10,$3 -> one stall
        add(10, 1, 2);
        tick();
        beq(10, 3);
        peek();
        check("ba_stall", 32'(bus.Stall__o), 32'd1);
        tick();
        peek();
        check("ba_after", 32'(bus.Stall__o), 32'd0);
        tick();

        // Destination $0 never creates a dependency
        add(0, 1, 2);
        tick();
        beq(0, 3);
        peek();
        check("zero_nostall", 32'(bus.Stall__o), 32'd0);
        tick();

        // Both sources match the load: still a single stall
        lw(11, 1);
        tick();
        add(12, 11, 11);
        peek();
        check("both_stall", 32'(bus.Stall__o), 32'd1);
        tick();
        peek();
        check("both_after", 32'(bus.Stall__o), 32'd0);
        tick();

        // Rt of an immediate-form load is not a source; Rt of a store is
        lw(13, 1);
        tick();
        lw(13, 2);
        peek();
        check("rt_unused", 32'(bus.Stall__o), 32'd0);
        tick();
        sw(13, 2);
        peek();
        check("sw_rt_used", 32'(bus.Stall__o), 32'd1);
        tick();
        tick();

        // Flush in the HOLD cycle: bubble, back to RUN, no further stall
        lw(9, 1);
        tick();
        beq(3, 9);
        tick();
        bus.Flush__i = 1'b1;
        peek();
        check("fl_hold_stall", 32'(bus.Stall__o), 32'd1);
        check("fl_hold_pcw", 32'(bus.PCWrite__o), 32'd0);
        tick();
        bus.Flush__i = 1'b0;
        peek();
        check("fl_after", 32'(bus.Stall__o), 32'd0);
        check("fl_bubble_mr", 32'(bus.IDEX_MemRead__o), 32'd0);
        tick();

        // Flush of a plain instruction loads a bubble
        add(14, 1, 2);
        bus.Flush__i = 1'b1;
        tick();
        bus.Flush__i = 1'b0;
        check("fl_plain_rw", 32'(bus.IDEX_RegWrite__o), 32'd0);
        nop();
        tick();

        // Reset asserted during HOLD discards the pending stall
        lw(9, 1);
        tick();
        beq(3, 9);
        tick();
        reset_n = 1'b0;
        #1;
        check("rh_mr", 32'(bus.IDEX_MemRead__o), 32'd0);
        check("rh_rs", 32'(bus.IDEX_RegRs__o), 32'd0);
        check("rh_pcw", 32'(bus.PCWrite__o), 32'd1);
        check("rh_cnt", 32'(bus.StallCount__o), 32'd0);
        tick();
        reset_n = 1'b1;
        peek();
        check("rh_run", 32'(bus.Stall__o), 32'd0);
        tick();
        nop();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
